// File: rtl/urng_pkg.sv
// Shared constants and helpers for the lfsr258 combined Tausworthe generator.
// Shift/mask sets per component, seed minima and the seed legalisation rule.
package urng_pkg;

    localparam int WIDTH = 64;

    localparam int Q1 = 1;
    localparam int S1 = 53;
    localparam int K1 = 10;
    localparam logic [WIDTH-1:0] M1 = 64'hFFFF_FFFF_FFFF_FFFE;

    localparam int Q2 = 24;
    localparam int S2 = 50;
    localparam int K2 = 5;
    localparam logic [WIDTH-1:0] M2 = 64'hFFFF_FFFF_FFFF_FE00;

    localparam int Q3 = 3;
    localparam int S3 = 23;
    localparam int K3 = 29;
    localparam logic [WIDTH-1:0] M3 = 64'hFFFF_FFFF_FFFF_F000;

    localparam int Q4 = 5;
    localparam int S4 = 24;
    localparam int K4 = 23;
    localparam logic [WIDTH-1:0] M4 = 64'hFFFF_FFFF_FFFE_0000;

    localparam int Q5 = 3;
    localparam int S5 = 33;
    localparam int K5 = 8;
    localparam logic [WIDTH-1:0] M5 = 64'hFFFF_FFFF_FF80_0000;

    // A component state at or below its minimum degenerates, so it is not a legal seed.
    localparam logic [WIDTH-1:0] MIN_Z1 = 64'd1;
    localparam logic [WIDTH-1:0] MIN_Z2 = 64'd511;
    localparam logic [WIDTH-1:0] MIN_Z3 = 64'd4095;
    localparam logic [WIDTH-1:0] MIN_Z4 = 64'd131071;
    localparam logic [WIDTH-1:0] MIN_Z5 = 64'd8388607;

    localparam logic [WIDTH-1:0] DEF_SEED1 = 64'h0123_4567_89AB_CDEF;
    localparam logic [WIDTH-1:0] DEF_SEED2 = 64'hFEDC_BA98_7654_3210;
    localparam logic [WIDTH-1:0] DEF_SEED3 = 64'h0F1E_2D3C_4B5A_6978;
    localparam logic [WIDTH-1:0] DEF_SEED4 = 64'h8796_A5B4_C3D2_E1F0;
    localparam logic [WIDTH-1:0] DEF_SEED5 = 64'h1357_9BDF_2468_ACE0;

    localparam logic [WIDTH-1:0] SEED_FIX_BIT = 64'h8000_0000_0000_0000;

    function automatic logic [WIDTH-1:0] seed_legalise(
        input logic [WIDTH-1:0] seed,
        input logic [WIDTH-1:0] min_val
    );
        return (seed <= min_val) ? (seed | SEED_FIX_BIT) : seed;
    endfunction

endpackage

// File: rtl/tausworthe_comp.sv
// One combinational Tausworthe component step: z -> z'.
// Latency: zero (pure logic). Backpressure: none, no handshake.
module tausworthe_comp
    import urng_pkg::*;
#(
    parameter int               Q = 1,
    parameter int               S = 53,
    parameter int               K = 10,
    parameter logic [WIDTH-1:0] M = 64'hFFFF_FFFF_FFFF_FFFE
) (
    input  logic [WIDTH-1:0] z,
    output logic [WIDTH-1:0] z_next
);

    logic [WIDTH-1:0] feedback;

    always_comb begin
        feedback = ((z << Q) ^ z) >> S;
        z_next   = ((z & M) << K) ^ feedback;
    end

endmodule

// File: rtl/urng_64.sv
// 64-bit lfsr258 uniform random word source for the Rx noise chain.
// Latency: one cycle from en sampled high to rand_out_valid. Backpressure: none.
module urng_64
    import urng_pkg::*;
#(
    parameter logic [WIDTH-1:0] SEED1 = DEF_SEED1,
    parameter logic [WIDTH-1:0] SEED2 = DEF_SEED2,
    parameter logic [WIDTH-1:0] SEED3 = DEF_SEED3,
    parameter logic [WIDTH-1:0] SEED4 = DEF_SEED4,
    parameter logic [WIDTH-1:0] SEED5 = DEF_SEED5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    output logic [WIDTH-1:0] rand_out,
    output logic             rand_out_valid
);

    localparam logic [WIDTH-1:0] SEED1_L = seed_legalise(SEED1, MIN_Z1);
    localparam logic [WIDTH-1:0] SEED2_L = seed_legalise(SEED2, MIN_Z2);
    localparam logic [WIDTH-1:0] SEED3_L = seed_legalise(SEED3, MIN_Z3);
    localparam logic [WIDTH-1:0] SEED4_L = seed_legalise(SEED4, MIN_Z4);
    localparam logic [WIDTH-1:0] SEED5_L = seed_legalise(SEED5, MIN_Z5);

    logic [WIDTH-1:0] z1, z2, z3, z4, z5;
    logic [WIDTH-1:0] z1_next, z2_next, z3_next, z4_next, z5_next;
    logic [WIDTH-1:0] word_next;

    tausworthe_comp #(.Q(Q1), .S(S1), .K(K1), .M(M1)) u_comp1 (.z(z1), .z_next(z1_next));
    tausworthe_comp #(.Q(Q2), .S(S2), .K(K2), .M(M2)) u_comp2 (.z(z2), .z_next(z2_next));
    tausworthe_comp #(.Q(Q3), .S(S3), .K(K3), .M(M3)) u_comp3 (.z(z3), .z_next(z3_next));
    tausworthe_comp #(.Q(Q4), .S(S4), .K(K4), .M(M4)) u_comp4 (.z(z4), .z_next(z4_next));
    tausworthe_comp #(.Q(Q5), .S(S5), .K(K5), .M(M5)) u_comp5 (.z(z5), .z_next(z5_next));

    // Output is combined from the next states so the word appears with the step that made it.
    always_comb begin
        word_next = z1_next ^ z2_next ^ z3_next ^ z4_next ^ z5_next;
    end

    // rstn is active-high here; it wins over en.
    always_ff @(posedge clk) begin
        if (rstn) begin
            z1             <= SEED1_L;
            z2             <= SEED2_L;
            z3             <= SEED3_L;
            z4             <= SEED4_L;
            z5             <= SEED5_L;
            rand_out       <= '0;
            rand_out_valid <= 1'b0;
        end else if (en) begin
            z1             <= z1_next;
            z2             <= z2_next;
            z3             <= z3_next;
            z4             <= z4_next;
            z5             <= z5_next;
            rand_out       <= word_next;
            rand_out_valid <= 1'b1;
        end else begin
            rand_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_urng_64.sv
// Directed bench for urng_64: scoreboard of model words against two instances
// (default seeds and SEED1/SEED5 overridden with illegal values).
module tb_urng_64;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en;
    logic [63:0] out_a, out_b;
    logic        vld_a, vld_b;

    int checks   = 0;
    int failures = 0;

    logic [63:0] q_a[$];
    logic [63:0] q_b[$];
    logic [63:0] ma[5];
    logic [63:0] mb[5];
    logic [63:0] last_a, last_b;
    logic [63:0] ref_words[256];
    int          n_out;
    bit          recording, replaying;

    always #5 clk = ~clk;

    urng_64 dut (
        .clk(clk), .rstn(rstn), .en(en), .rand_out(out_a), .rand_out_valid(vld_a)
    );

    urng_64 #(.SEED1(64'd0), .SEED5(64'd100)) dut2 (
        .clk(clk), .rstn(rstn), .en(en), .rand_out(out_b), .rand_out_valid(vld_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] comp(input logic [63:0] z, input int idx);
        int q, s, k;
        logic [63:0] m, b;
        case (idx)
            0:       begin q = 1;  s = 53; k = 10; m = 64'hFFFF_FFFF_FFFF_FFFE; end
            1:       begin q = 24; s = 50; k = 5;  m = 64'hFFFF_FFFF_FFFF_FE00; end
            2:       begin q = 3;  s = 23; k = 29; m = 64'hFFFF_FFFF_FFFF_F000; end
            3:       begin q = 5;  s = 24; k = 23; m = 64'hFFFF_FFFF_FFFE_0000; end
            default: begin q = 3;  s = 33; k = 8;  m = 64'hFFFF_FFFF_FF80_0000; end
        endcase
        b = ((z << q) ^ z) >> s;
        return ((z & m) << k) ^ b;
    endfunction

    task automatic seed_models();
        ma[0] = 64'h0123_4567_89AB_CDEF; ma[1] = 64'hFEDC_BA98_7654_3210;
        ma[2] = 64'h0F1E_2D3C_4B5A_6978; ma[3] = 64'h8796_A5B4_C3D2_E1F0;
        ma[4] = 64'h1357_9BDF_2468_ACE0;
        mb    = ma;
        mb[0] = 64'h8000_0000_0000_0000;
        mb[4] = 64'h8000_0000_0000_0064;
    endtask

    task automatic advance_models();
        logic [64-1:0] wa, wb;
        wa = '0;
        wb = '0;
        for (int i = 0; i < 5; i++) begin
            ma[i] = comp(ma[i], i);
            mb[i] = comp(mb[i], i);
            wa ^= ma[i];
            wb ^= mb[i];
        end
        q_a.push_back(wa);
        q_b.push_back(wb);
    endtask

    // One clock: drive inputs, step the scoreboard, then check both instances after the edge.
    task automatic cycle(input logic r, input logic e);
        logic [63:0] exp_a, exp_b;
        rstn = r;
        en   = e;
        if (r) begin
            seed_models();
            q_a.delete();
            q_b.delete();
        end else if (e) begin
            advance_models();
        end
        @(posedge clk);
        #1;
        chk("valid_a", {63'd0, vld_a}, {63'd0, (!r && e)});
        chk("valid_b", {63'd0, vld_b}, {63'd0, (!r && e)});
        if (r) begin
            exp_a = '0;
            exp_b = '0;
            n_out = 0;
        end else if (e) begin
            if (q_a.size() == 0 || q_b.size() == 0) begin
                chk("scoreboard_empty", 64'd1, 64'd0);
                exp_a = last_a;
                exp_b = last_b;
            end else begin
                exp_a = q_a.pop_front();
                exp_b = q_b.pop_front();
            end
            if (recording && n_out < 256) ref_words[n_out] = exp_a;
            if (replaying && n_out < 256) chk($sformatf("replay_w%0d", n_out), out_a, ref_words[n_out]);
            n_out++;
        end else begin
            exp_a = last_a;
            exp_b = last_b;
        end
        chk(r ? "reset_out_a" : (e ? "word_a" : "hold_a"), out_a, exp_a);
        chk(r ? "reset_out_b" : (e ? "word_b" : "hold_b"), out_b, exp_b);
        last_a = exp_a;
        last_b = exp_b;
    endtask

    initial begin
        int          ones[64];
        int          dups;
        bit          seen[logic [63:0]];

        rstn      = 1'b1;
        en        = 1'b1;
        recording = 1'b0;
        replaying = 1'b0;
        n_out     = 0;
        last_a    = '0;
        last_b    = '0;

        // Reset held with en high: outputs stay zero, states load (legalised) seeds.
        repeat (3) cycle(1'b1, 1'b1);
        chk("z1_seed", dut.z1, 64'h0123_4567_89AB_CDEF);
        chk("z2_seed", dut.z2, 64'hFEDC_BA98_7654_3210);
        chk("z3_seed", dut.z3, 64'h0F1E_2D3C_4B5A_6978);
        chk("z4_seed", dut.z4, 64'h8796_A5B4_C3D2_E1F0);
        chk("z5_seed", dut.z5, 64'h1357_9BDF_2468_ACE0);
        chk("z1_legal", dut2.z1, 64'h8000_0000_0000_0000);
        chk("z5_legal", dut2.z5, 64'h8000_0000_0000_0064);
        chk("z2_default_b", dut2.z2, 64'hFEDC_BA98_7654_3210);

        // Fresh run of 106 words, recorded for the mid-run reset replay.
        recording = 1'b1;
        repeat (106) cycle(1'b0, 1'b1);

        // Enable toggling: valid 1,0,0,1, output holds, no word skipped.
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        repeat (40) cycle(1'b0, 1'b1);
        recording = 1'b0;

        // Mid-run reset restarts exactly from the seeds.
        repeat (2) cycle(1'b1, 1'b0);
        replaying = 1'b1;
        repeat (60) cycle(1'b0, 1'b1);
        replaying = 1'b0;

        // Bit balance and repeat-freedom over a short window.
        for (int i = 0; i < 64; i++) ones[i] = 0;
        dups = 0;
        for (int n = 0; n < 8192; n++) begin
            cycle(1'b0, 1'b1);
            for (int i = 0; i < 64; i++) ones[i] += int'(out_a[i]);
            if (seen.exists(out_a)) dups++;
            seen[out_a] = 1'b1;
        end
        for (int i = 0; i < 64; i++)
            chk($sformatf("bit%0d_balance", i),
                {63'd0, (ones[i] >= 3769 && ones[i] <= 4423)}, 64'd1);
        chk("no_repeat", 64'(dups), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
